// File: rtl/clk_test_pkg.sv
// Shared types and helpers for the clock pattern generator and the measurement side.
package clk_test_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam int CNT_W_DEF = 16;
  localparam int PER_W_DEF = 32;
  localparam int MAX_W     = 32;

  // Zero-length phases are meaningless; the shortest legal phase is one cycle.
  function automatic logic [MAX_W-1:0] clamp_min1(input logic [MAX_W-1:0] v);
    return (v == '0) ? MAX_W'(1) : v;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Down-counter for one waveform phase: load a length, decrement, flag the last cycle.
module phase_counter
  import clk_test_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_term = (r_cnt == W'(1));

endmodule

// File: rtl/clock_pattern_gen.sv
// Programmable duty-cycle waveform generator; new high/low times take effect only
// at period boundaries so clk_out never produces a runt pulse.
module clock_pattern_gen
  import clk_test_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk_fst,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] ht_in,
  input  logic [CNT_W-1:0] lt_in,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic [PER_W-1:0] period_cnt
);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_pend_ht, r_pend_lt, r_act_ht, r_act_lt;
  logic             r_pend_v, r_act_v;
  logic             r_clk_out, r_rise_stb, r_fall_stb;
  logic [PER_W-1:0] r_period_cnt;

  logic             w_hs, w_apply, w_load, w_dec, w_term, w_period_done, w_high_next;
  logic [CNT_W-1:0] w_load_val, w_next_ht, w_ht_clamp, w_lt_clamp;

  assign w_ht_clamp  = CNT_W'(clamp_min1(MAX_W'(ht_in)));
  assign w_lt_clamp  = CNT_W'(clamp_min1(MAX_W'(lt_in)));
  assign w_hs        = cfg_valid & ~r_pend_v;
  // High time of the period about to start: pending config wins over active.
  assign w_next_ht   = r_pend_v ? r_pend_ht : r_act_ht;
  assign w_dec       = (r_state != IDLE) & ~w_term;
  assign w_high_next = (w_state_next == HIGH);

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_load_val    = w_next_ht;
    w_apply       = 1'b0;
    w_period_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_apply = r_pend_v;
        if (en && (r_act_v || r_pend_v)) begin
          w_state_next = HIGH;
          w_load       = 1'b1;
        end
      end
      HIGH: begin
        if (w_term) begin
          w_state_next = LOW;
          w_load       = 1'b1;
          w_load_val   = r_act_lt;
        end
      end
      LOW: begin
        if (w_term) begin
          w_period_done = 1'b1;
          if (en) begin
            w_state_next = HIGH;
            w_load       = 1'b1;
            w_apply      = r_pend_v;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .i_clk      (clk_fst),
    .i_rst_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_term     (w_term)
  );

  always_ff @(posedge clk_fst or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pend_ht    <= '0;
      r_pend_lt    <= '0;
      r_pend_v     <= 1'b0;
      r_act_ht     <= '0;
      r_act_lt     <= '0;
      r_act_v      <= 1'b0;
      r_clk_out    <= 1'b0;
      r_rise_stb   <= 1'b0;
      r_fall_stb   <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_apply) begin
        r_act_ht <= r_pend_ht;
        r_act_lt <= r_pend_lt;
        r_act_v  <= 1'b1;
      end
      // Handshake and apply are exclusive: one needs pend_v low, the other high.
      if (w_hs) begin
        r_pend_ht <= w_ht_clamp;
        r_pend_lt <= w_lt_clamp;
        r_pend_v  <= 1'b1;
      end else if (w_apply) begin
        r_pend_v <= 1'b0;
      end
      r_clk_out  <= w_high_next;
      r_rise_stb <= w_high_next & ~r_clk_out;
      r_fall_stb <= ~w_high_next & r_clk_out;
      if (w_period_done) begin
        r_period_cnt <= r_period_cnt + PER_W'(1);
      end
    end
  end

  assign cfg_ready  = ~r_pend_v;
  assign busy       = (r_state != IDLE);
  assign clk_out    = r_clk_out;
  assign rise_stb   = r_rise_stb;
  assign fall_stb   = r_fall_stb;
  assign period_cnt = r_period_cnt;

endmodule

// File: tb/tb_clock_pattern_gen.sv
// Directed, table-driven bench for clock_pattern_gen plus hand-written reset/recovery sequences.
module tb_clock_pattern_gen;

  logic        clk_fst   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        en        = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] ht_in     = '0;
  logic [15:0] lt_in     = '0;
  logic        cfg_ready, clk_out, rise_stb, fall_stb, busy;
  logic [31:0] period_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_fst = ~clk_fst;

  clock_pattern_gen dut (
    .clk_fst    (clk_fst),
    .reset_n    (reset_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .ht_in      (ht_in),
    .lt_in      (lt_in),
    .clk_out    (clk_out),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .busy       (busy),
    .period_cnt (period_cnt)
  );

  typedef struct {
    logic        en;
    logic        cv;
    logic [15:0] ht;
    logic [15:0] lt;
    logic        clk;
    logic        rise;
    logic        fall;
    logic        busy;
    logic        rdy;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic a_en, input logic a_cv, input logic [15:0] a_ht,
                              input logic [15:0] a_lt, input logic e_clk, input logic e_rise,
                              input logic e_fall, input logic e_busy, input logic e_rdy,
                              input logic [31:0] e_pc);
    vec_t v;
    v.en = a_en; v.cv = a_cv; v.ht = a_ht; v.lt = a_lt;
    v.clk = e_clk; v.rise = e_rise; v.fall = e_fall; v.busy = e_busy; v.rdy = e_rdy; v.pc = e_pc;
    vecs.push_back(v);
  endfunction

  // One full period with en=1; an optional config offer rides on the first (boundary) cycle.
  function automatic void add_period(input int h, input int l, input logic [31:0] pc,
                                     input logic cv0, input logic [15:0] cht, input logic [15:0] clt,
                                     input logic rdy0, input logic rdy_rest);
    for (int i = 0; i < h; i++)
      add(1'b1, (i == 0) ? cv0 : 1'b0, (i == 0) ? cht : 16'd0, (i == 0) ? clt : 16'd0,
          1'b1, i == 0, 1'b0, 1'b1, (i == 0) ? rdy0 : rdy_rest, pc);
    for (int i = 0; i < l; i++)
      add(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, i == 0, 1'b1, rdy_rest, pc);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;

    // Idle after reset
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Load 3/5 while idle, then run four periods
    add(0, 1, 3, 5, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int p = 0; p < 4; p++) add_period(3, 5, p, 0, 0, 0, 1, 1);
    // Offer 2/2 on the boundary cycle: held for one more 3/5 period
    add_period(3, 5, 4, 1, 2, 2, 0, 0);
    add_period(2, 2, 5, 0, 0, 0, 1, 1);
    // Offer 3/5 back on the boundary cycle of a 2/2 period
    add_period(2, 2, 6, 1, 3, 5, 0, 0);
    // 3/5 period, en dropped during the high phase: run to completion then IDLE
    add(1, 0, 0, 0, 1, 1, 0, 1, 1, 7);
    add(1, 0, 0, 0, 1, 0, 0, 1, 1, 7);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1, 7);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, i == 0, 1, 1, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    // ht=0 lt=1 clamps to 1/1; enable in the cycle right after the handshake
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 8);
    add(1, 0, 0, 0, 1, 1, 0, 1, 1, 8);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 8);
    add(1, 0, 0, 0, 1, 1, 0, 1, 1, 9);
    add(1, 0, 0, 0, 0, 0, 1, 1, 1, 9);
    add(1, 0, 0, 0, 1, 1, 0, 1, 1, 10);

    #22 reset_n = 1'b1;

    foreach (vecs[k]) begin
      en        = vecs[k].en;
      cfg_valid = vecs[k].cv;
      ht_in     = vecs[k].ht;
      lt_in     = vecs[k].lt;
      @(posedge clk_fst);
      #1;
      $display("vec %0d en=%0b cv=%0b clk_out=%0b rise=%0b fall=%0b busy=%0b rdy=%0b pc=%0d",
               k, en, cfg_valid, clk_out, rise_stb, fall_stb, busy, cfg_ready, period_cnt);
      check($sformatf("vec%0d", k),
            {27'd0, clk_out, rise_stb, fall_stb, busy, cfg_ready, period_cnt},
            {27'd0, vecs[k].clk, vecs[k].rise, vecs[k].fall, vecs[k].busy, vecs[k].rdy, vecs[k].pc});
    end
    cfg_valid = 1'b0;

    // Async reset between edges while clk_out is high
    #2 reset_n = 1'b0;
    #1;
    $display("async reset: clk_out=%0b busy=%0b rdy=%0b pc=%0d", clk_out, busy, cfg_ready, period_cnt);
    check("async_rst", {clk_out, busy, cfg_ready, rise_stb, fall_stb, period_cnt},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk_fst);
    reset_n = 1'b1;

    // en held high with no config: must stay idle
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_fst);
      #1;
      $display("post-reset %0d clk_out=%0b busy=%0b", i, clk_out, busy);
      check($sformatf("post_rst%0d", i), {clk_out, rise_stb, busy}, 3'b000);
    end

    // New config brings it back to life within a bounded number of cycles
    cfg_valid = 1'b1; ht_in = 16'd2; lt_in = 16'd2;
    @(posedge clk_fst);
    #1;
    cfg_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk_fst);
      #1;
      if (rise_stb) got = 1'b1;
    end
    $display("recovery: rise seen=%0b", got);
    check("recover_rise", {63'd0, got}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
